// File: rtl/lsu.sv
// Load/store unit: one memory op per transaction, valid/ready toward data memory,
// load alignment and extension, error response on misalignment, bad funct3 or timeout.
module lsu #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] mem_data_out,
    output logic        dmem_valid,
    input  logic        dmem_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_wen,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MAX_WAIT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [1:0]  off_r;
    logic [2:0]  funct3_r;
    logic        is_store_r;
    logic        req_legal_s;
    logic        timeout_s;

    function automatic logic is_legal(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] a);
        logic ok;
        case (f3)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (a[0] == 1'b0);
            3'd2:    ok = (a == 2'b00);
            3'd4:    ok = !is_store;
            3'd5:    ok = !is_store && (a[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        case (f3[1:0])
            2'd0:    s = 4'b0001 << a;
            2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'd0:    w = {4{d[7:0]}};
            2'd1:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] rdata);
        logic [31:0] s;
        logic [31:0] r;
        s = rdata >> {a, 3'b000};
        case (f3)
            3'd0:    r = {{24{s[7]}}, s[7:0]};
            3'd1:    r = {{16{s[15]}}, s[15:0]};
            3'd4:    r = {24'h000000, s[7:0]};
            3'd5:    r = {16'h0000, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    assign req_legal_s = is_legal(req_is_store, req_funct3, req_addr[1:0]);
    assign timeout_s   = (cnt_r == TIMEOUT_CNT);

    // Handshake outputs depend on state only, so no input reaches an output combinationally.
    assign req_ready  = (state_r == IDLE);
    assign dmem_valid = (state_r == REQ);
    assign resp_valid = (state_r == RESP);

    // Transaction FSM with registered memory-side and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            off_r        <= 2'd0;
            funct3_r     <= 3'd0;
            is_store_r   <= 1'b0;
            resp_err     <= 1'b0;
            mem_data_out <= 32'h0000_0000;
            dmem_addr    <= 32'h0000_0000;
            dmem_wen     <= 1'b0;
            dmem_wstrb   <= 4'b0000;
            dmem_wdata   <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        cnt_r      <= 8'd0;
                        off_r      <= req_addr[1:0];
                        funct3_r   <= req_funct3;
                        is_store_r <= req_is_store;
                        if (req_legal_s) begin
                            state_r    <= REQ;
                            resp_err   <= 1'b0;
                            dmem_addr  <= {req_addr[31:2], 2'b00};
                            dmem_wen   <= req_is_store;
                            dmem_wstrb <= req_is_store ? store_strb(req_funct3, req_addr[1:0])
                                                       : 4'b0000;
                            dmem_wdata <= req_is_store ? store_data(req_funct3, req_wdata)
                                                       : 32'h0000_0000;
                        end else begin
                            state_r  <= RESP;
                            resp_err <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    cnt_r <= cnt_r + 8'd1;
                    // A handshake in the timeout cycle still completes the request.
                    if (dmem_ready) begin
                        state_r    <= is_store_r ? RESP : WAIT;
                        dmem_wen   <= 1'b0;
                        dmem_wstrb <= 4'b0000;
                    end else if (timeout_s) begin
                        state_r    <= RESP;
                        resp_err   <= 1'b1;
                        dmem_wen   <= 1'b0;
                        dmem_wstrb <= 4'b0000;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (dmem_rvalid) begin
                        mem_data_out <= load_extract(funct3_r, off_r, dmem_rdata);
                        state_r      <= RESP;
                    end else if (timeout_s) begin
                        state_r  <= RESP;
                        resp_err <= 1'b1;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                RESP: begin
                    state_r  <= IDLE;
                    resp_err <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a transaction-level model predicts responses, strobes and
// load results; one monitor compares the DUT against it every cycle.
module tb_lsu;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] mem_data_out;
    logic        dmem_valid;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;

    lsu #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .mem_data_out(mem_data_out),
        .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
        .dmem_wen(dmem_wen), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic        err;
        logic [31:0] mdo;
    } resp_t;

    resp_t       exp_q[$];
    resp_t       mon_e;
    logic [31:0] cur_mdo = 32'h0;
    logic [31:0] model_mdo = 32'h0;
    logic [31:0] exp_addr = 32'h0;
    logic        exp_wen = 1'b0;
    logic [3:0]  exp_strb = 4'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [31:0] obs_addr = 32'h0;
    logic [31:0] obs_wdata = 32'h0;
    logic        obs_wen = 1'b0;
    logic [3:0]  obs_strb = 4'h0;
    int          last_lat = 0;
    int          last_vcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic m_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic f3_ok;
        int   size;
        if (st) f3_ok = (f3 <= 3'd2);
        else    f3_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = 1 << f3[1:0];
        return f3_ok && ((a % size) == 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [7:0]  bl [4];
        int          off;
        byte         sb;
        shortint     sh;
        int          iv;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) bl[i] = rd[8*i +: 8];
        off = int'(a[1:0]);
        sb  = bl[off];
        sh  = (off < 3) ? {bl[off+1], bl[off]} : 16'h0000;
        case (f3)
            3'd0:    begin iv = sb; r = iv; end
            3'd1:    begin iv = sh; r = iv; end
            3'd4:    r = {24'h000000, bl[off]};
            3'd5:    r = {16'h0000, sh};
            default: r = rd;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s;
        int size;
        int off;
        size = 1 << f3[1:0];
        off  = int'(a[1:0]);
        for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + size);
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % size) +: 8];
        return w;
    endfunction

    // Per-cycle comparison of DUT outputs against the model's expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL resp_unexpected: resp_valid=1 expected 0");
                end else begin
                    mon_e   = exp_q.pop_front();
                    cur_mdo = mon_e.mdo;
                    chk("resp_err", 32'(resp_err), 32'(mon_e.err));
                end
            end
            chk("mem_data_out", mem_data_out, cur_mdo);
            if (dmem_valid) begin
                chk("dmem_addr", dmem_addr, exp_addr);
                chk("dmem_wen", 32'(dmem_wen), 32'(exp_wen));
                if (exp_wen) begin
                    chk("dmem_wstrb", 32'(dmem_wstrb), 32'(exp_strb));
                    chk("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end
        end
    end

    // rdly: cycles dmem_ready stays low in REQ; rg: edges from handshake to rvalid (>=1).
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int rdly, input int rg,
                          input logic [31:0] rdv);
        logic  legal;
        logic  tout;
        int    exp_lat;
        int    exp_vc;
        int    k;
        bit    done;
        resp_t e;
        legal = m_legal(st, f3, addr);
        tout  = legal && ((st ? rdly + 1 : rdly + rg + 1) > MAXW);
        if (!legal) begin
            exp_lat = 1; exp_vc = 0;
        end else if (tout) begin
            exp_lat = MAXW + 1; exp_vc = (rdly + 1 > MAXW) ? MAXW : rdly + 1;
        end else if (st) begin
            exp_lat = rdly + 2; exp_vc = rdly + 1;
        end else begin
            exp_lat = rdly + rg + 2; exp_vc = rdly + 1;
        end
        if (legal && !st && !tout) model_mdo = m_load(f3, addr, rdv);
        e.err = !legal || tout;
        e.mdo = model_mdo;
        exp_q.push_back(e);
        exp_addr  = {addr[31:2], 2'b00};
        exp_wen   = st;
        exp_strb  = m_strb(f3, addr);
        exp_wdata = m_wdata(f3, wd);

        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_funct3 = 3'd7;
        k = 0; done = 1'b0; last_vcnt = 0;
        while (!done && k < 30) begin
            dmem_ready  = legal && (k == rdly);
            dmem_rvalid = legal && !st && (k == rdly + rg);
            dmem_rdata  = rdv;
            @(negedge clk);
            if (dmem_valid) begin
                last_vcnt++;
                obs_addr = dmem_addr; obs_wen = dmem_wen;
                obs_strb = dmem_wstrb; obs_wdata = dmem_wdata;
            end
            if (resp_valid) begin
                done = 1'b1;
                last_lat = k + 1;
            end else begin
                chk("req_ready_busy", 32'(req_ready), 32'd0);
            end
            @(posedge clk); #1;
            k++;
        end
        dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        if (!done) begin
            checks++;
            errs++;
            $display("FAIL resp_wait: no resp_valid within 30 cycles, expected latency %0d", exp_lat);
        end else begin
            chk("latency", 32'(last_lat), 32'(exp_lat));
            chk("dmem_valid_cycles", 32'(last_vcnt), 32'(exp_vc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_dmem_valid", 32'(dmem_valid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_dmem_wen", 32'(dmem_wen), 32'd0);
        chk("rst_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk("rst_mdo", mem_data_out, 32'h0);
        @(posedge clk); #1;

        // Hand-computed values pinning the model.
        chk("model_lb3", m_load(3'd0, 32'h3, 32'h80FF_7F01), 32'hFFFF_FF80);
        chk("model_lh2", m_load(3'd1, 32'h2, 32'h80FF_7F01), 32'hFFFF_80FF);
        chk("model_sh_strb", 32'(m_strb(3'd1, 32'h2)), 32'h0000_000C);
        chk("model_sb_data", m_wdata(3'd0, 32'h0000_00AB), 32'hABAB_ABAB);

        // LW with immediate memory response.
        run_op(1'b0, 3'd2, 32'h8000_0004, 32'h0, 0, 1, 32'hDEAD_BEEF);
        chk("lw_addr", obs_addr, 32'h8000_0004);
        chk("lw_wen", 32'(obs_wen), 32'd0);
        chk("lw_lat", 32'(last_lat), 32'd3);
        chk("lw_data", mem_data_out, 32'hDEAD_BEEF);

        // Sub-word loads.
        run_op(1'b0, 3'd0, 32'h1000_0003, 32'h0, 0, 1, 32'h80FF_7F01);
        chk("lb3", mem_data_out, 32'hFFFF_FF80);
        run_op(1'b0, 3'd4, 32'h1000_0003, 32'h0, 1, 2, 32'h80FF_7F01);
        chk("lbu3", mem_data_out, 32'h0000_0080);
        run_op(1'b0, 3'd1, 32'h1000_0002, 32'h0, 0, 1, 32'h80FF_7F01);
        chk("lh2", mem_data_out, 32'hFFFF_80FF);
        run_op(1'b0, 3'd5, 32'h1000_0000, 32'h0, 2, 1, 32'h80FF_7F01);
        chk("lhu0", mem_data_out, 32'h0000_7F01);
        run_op(1'b0, 3'd0, 32'h1000_0001, 32'h0, 0, 3, 32'h80FF_7F01);
        chk("lb1", mem_data_out, 32'h0000_007F);

        // Stores.
        run_op(1'b1, 3'd0, 32'h2000_0002, 32'h0000_00AB, 0, 1, 32'h0);
        chk("sb_strb", 32'(obs_strb), 32'h4);
        chk("sb_data", obs_wdata, 32'hABAB_ABAB);
        chk("sb_lat", 32'(last_lat), 32'd2);
        run_op(1'b1, 3'd1, 32'h2000_0002, 32'h0000_1234, 0, 1, 32'h0);
        chk("sh_strb", 32'(obs_strb), 32'hC);
        chk("sh_data", obs_wdata, 32'h1234_1234);
        run_op(1'b1, 3'd2, 32'h2000_0008, 32'h1122_3344, 0, 1, 32'h0);
        chk("sw_strb", 32'(obs_strb), 32'hF);
        chk("sw_data", obs_wdata, 32'h1122_3344);
        run_op(1'b1, 3'd0, 32'h2000_0001, 32'h0000_005A, 5, 1, 32'h0);
        chk("stall_lat", 32'(last_lat), 32'd7);
        chk("stall_vcnt", 32'(last_vcnt), 32'd6);
        chk("mdo_after_store", mem_data_out, 32'h0000_007F);

        // Misaligned and illegal funct3.
        run_op(1'b0, 3'd2, 32'h2000_0002, 32'h0, 0, 1, 32'h1111_1111);
        chk("lw_mis_lat", 32'(last_lat), 32'd1);
        run_op(1'b1, 3'd1, 32'h2000_0001, 32'h0000_BEEF, 0, 1, 32'h0);
        chk("sh_mis_lat", 32'(last_lat), 32'd1);
        run_op(1'b0, 3'd3, 32'h2000_0000, 32'h0, 0, 1, 32'h2222_2222);
        run_op(1'b1, 3'd4, 32'h2000_0000, 32'h0, 0, 1, 32'h0);
        chk("mdo_after_err", mem_data_out, 32'h0000_007F);

        // Timeout, then late data in IDLE.
        run_op(1'b0, 3'd2, 32'h5000_0008, 32'h0, 100, 1, 32'h0);
        chk("timeout_lat", 32'(last_lat), 32'd9);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("late_rvalid_mdo", mem_data_out, 32'h0000_007F);

        // Load whose data arrives on the last allowed cycle completes rather than timing out.
        run_op(1'b0, 3'd2, 32'h5000_0010, 32'h0, 3, 4, 32'h0BAD_CAFE);
        chk("edge_completion", mem_data_out, 32'h0BAD_CAFE);

        // Reset while in WAIT.
        exp_addr = 32'h3000_0000; exp_wen = 1'b0;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h3000_0000;
        @(posedge clk); #1;
        req_valid = 1'b0; dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        rst = 1'b1; cur_mdo = 32'h0; model_mdo = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_idle", 32'(req_ready), 32'd1);
        chk("rst_wait_dvalid", 32'(dmem_valid), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Back-to-back loads.
        run_op(1'b0, 3'd2, 32'h4000_0000, 32'h0, 0, 1, 32'h1111_1111);
        run_op(1'b0, 3'd2, 32'h4000_0004, 32'h0, 0, 1, 32'h2222_2222);
        chk("b2b_data", mem_data_out, 32'h2222_2222);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
